regs_top: RTL and testbench
===========================

Name: regs_top

Overview:
- Register-file lab top: 32 x 32-bit general registers (r0 hardwired to zero), loaded from a 32-bit data input under switch control.
- Separate latched write-address, read-address and write-data registers feed the register array.
- A selected read port is captured onto Output_Data and shown as 8 hex digits on a multiplexed 7-segment display (which/led), plus a blink indicator (shine).

Parameters:
- SCAN_BITS, 2, display scan divider: digit index advances every 2^SCAN_BITS Clk cycles.
- BLINK_BIT, 3, bit of the free-running scan counter driving shine.

Ports:
- Clk  input  1  sole clock; everything is updated on its rising edge.
- SW  input  6  SW[0] = reset (synchronous, active-high); SW[1] = load addresses; SW[2] = load write data; SW[3] = register write; SW[4] = capture output; SW[5] = read-port select (0 = A, 1 = B).
- Input_Data  input  [32:1]  address word or write data; bit 1 is the LSB.
- Output_Data  output  [32:1]  captured read data.
- which  output  3  active display digit index 0..7; digit k shows nibble k of Output_Data (k=0 is least significant).
- led  output  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
- shine  output  1  blink indicator.

Behaviour:
- One clock domain. Reset is SW[0], synchronous and active-high, sampled at the Clk rising edge, and overrides all other switches.
- Reset clears: all 32 registers, W_Addr, RA_Addr, RB_Addr, W_Data, Output_Data, scan counter, which, shine. After reset, led = 8'hC0 (digit 0).
- All switches are level-sensitive: the action repeats on every Clk edge while the switch is high. Repeated actions are idempotent.
- SW[1]: W_Addr <= Input_Data[5:1]; RA_Addr <= Input_Data[13:9]; RB_Addr <= Input_Data[21:17]. Other bits are ignored.
- SW[2]: W_Data <= Input_Data.
- SW[3]: reg[W_Addr] <= W_Data, using the values of W_Addr and W_Data from before this edge. Writes to r0 are discarded; r0 always reads 0.
- Read ports are combinational: A = reg[RA_Addr], B = reg[RB_Addr].
- SW[4]: Output_Data <= SW[5] ? B : A. The capture sees pre-write contents if SW[3] is high in the same cycle (no bypass).
- SW[1], SW[2], SW[3] and SW[4] may be high together; each acts independently using pre-edge values.
- Display:
  - A free-running counter increments every Clk.
  - which = counter[SCAN_BITS+2 : SCAN_BITS]; it wraps 7 -> 0.
  - led is combinational from nibble[which] via the active-low hex table: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
- shine = counter[SCAN_BITS+BLINK_BIT]; it is 0 during and immediately after reset.

Decomposition:
- Shared package: register count (32), address width (5), data width (32), the SW bit index constants, and the hex-to-segment table constants.
- One natural sub-module: seg7_decoder (4-bit nibble -> 8-bit active-low pattern).
- Register array, latches and scan counter stay in regs_top.

Test Plan:
- Reset with SW[0]=1 for one edge -> Output_Data=0, which=0, led=8'hC0, shine=0; all registers read 0.
- Load addresses 0 and data 32'hFFFF_FFFF, pulse SW[3], capture with SW[4] -> Output_Data stays 0 (r0 write ignored).
- Load addresses 32'h004A_0F01 (W=1, A=15, B=10) and data 32'h0000_00F1, pulse SW[3]; then load addresses 32'h0000_0100 (A=1) and pulse SW[4] with SW[5]=0 -> Output_Data=32'h0000_00F1.
- Same state with SW[5]=1 and RB_Addr=1 (address word 32'h0001_0000) -> Output_Data=32'h0000_00F1.
- SW[4] held in the same cycle as an SW[3] write to register 1 with new data -> old value captured; the next capture returns the new value.
- Free-run 64 Clk with Output_Data=32'h0000_00F1, SCAN_BITS=2:
  - which steps 0..7 every 4 cycles.
  - led = 8'hF9 at which=0 and 8'h8E at which=1; led = 8'hC0 for digits 2..7.
  - shine toggles every 32 cycles.

Source files
------------

// File: rtl/regs_pkg.sv
// Shared constants for the register-file lab top:
// array geometry, switch bit positions and the 7-segment table.
package regs_pkg;

  localparam int NREGS = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  localparam int SW_RST = 0;
  localparam int SW_LDA = 1;
  localparam int SW_LDD = 2;
  localparam int SW_WR  = 3;
  localparam int SW_CAP = 4;
  localparam int SW_SEL = 5;

  // Active-low {dp,g,f,e,d,c,b,a}, entry n is hex digit n
  localparam logic [15:0][7:0] SEG_TAB = {
    8'h8E, 8'h86, 8'hA1, 8'hC6,
    8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99,
    8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low 7-segment pattern.
// The decimal point stays dark for every digit.
module seg7_decoder
  import regs_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] seg
);

  assign seg = SEG_TAB[nib];

endmodule

// File: rtl/regs_top.sv
// Register-file lab top: 32x32 array with latched addresses,
// write data and captured output shown on a scanned hex display.
module regs_top
  import regs_pkg::*;
#(
  parameter int SCAN_BITS = 2,
  parameter int BLINK_BIT = 3
) (
  input  logic        Clk,
  input  logic [5:0]  SW,
  input  logic [32:1] Input_Data,
  output logic [32:1] Output_Data,
  output logic [2:0]  which,
  output logic [7:0]  led,
  output logic        shine
);

  localparam int CW =
    SCAN_BITS + ((BLINK_BIT >= 3) ? BLINK_BIT + 1 : 3);

  logic [CW-1:0] scan;
  logic [DW-1:0] rf [NREGS];
  logic [AW-1:0] w_addr;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] w_data;
  logic [DW-1:0] out_q;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [3:0]    nib;

  // r0 is cleared by reset and never written, so it reads 0
  assign rd_a = rf[ra_addr];
  assign rd_b = rf[rb_addr];

  always_ff @(posedge Clk) begin
    if (SW[SW_RST]) begin
      for (int i = 0; i < NREGS; i++)
        rf[i] <= '0;
      w_addr  <= '0;
      ra_addr <= '0;
      rb_addr <= '0;
      w_data  <= '0;
      out_q   <= '0;
      scan    <= '0;
    end else begin
      scan <= scan + 1'b1;
      if (SW[SW_LDA]) begin
        w_addr  <= Input_Data[5:1];
        ra_addr <= Input_Data[13:9];
        rb_addr <= Input_Data[21:17];
      end
      if (SW[SW_LDD])
        w_data <= Input_Data;
      if (SW[SW_WR] && w_addr != '0)
        rf[w_addr] <= w_data;
      if (SW[SW_CAP])
        out_q <= SW[SW_SEL] ? rd_b : rd_a;
    end
  end

  assign Output_Data = out_q;
  assign which = scan[SCAN_BITS+2:SCAN_BITS];
  assign shine = scan[SCAN_BITS+BLINK_BIT];
  assign nib   = out_q[{which, 2'b00} +: 4];

  seg7_decoder u_seg (
    .nib (nib),
    .seg (led)
  );

endmodule

// File: tb/tb_regs_top.sv
// Self-checking bench for regs_top: directed cases plus
// random switch/data traffic against a behavioural model.
module tb_regs_top;

  logic        Clk = 1'b0;
  logic [5:0]  SW = '0;
  logic [32:1] Input_Data = '0;
  logic [32:1] Output_Data;
  logic [2:0]  which;
  logic [7:0]  led;
  logic        shine;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [32];
  logic [4:0]  m_wa, m_ra, m_rb;
  logic [31:0] m_wd, m_out;
  int          m_cnt;

  regs_top #(.SCAN_BITS(2), .BLINK_BIT(3)) dut (
    .Clk         (Clk),
    .SW          (SW),
    .Input_Data  (Input_Data),
    .Output_Data (Output_Data),
    .which       (which),
    .led         (led),
    .shine       (shine)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;
      4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;
      4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;
      4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;
      4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  function automatic void model(input logic [5:0] sw,
                                input logic [31:0] d);
    logic [31:0] cap;
    if (sw[0]) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_wa = '0; m_ra = '0; m_rb = '0;
      m_wd = '0; m_out = '0; m_cnt = 0;
      return;
    end
    cap = sw[5] ? m_rf[m_rb] : m_rf[m_ra];
    if (sw[3] && m_wa != 0) m_rf[m_wa] = m_wd;
    if (sw[4]) m_out = cap;
    if (sw[1]) begin
      m_wa = d[4:0]; m_ra = d[12:8]; m_rb = d[20:16];
    end
    if (sw[2]) m_wd = d;
    m_cnt = (m_cnt + 1) % 64;
  endfunction

  task automatic step(input logic [5:0] sw,
                      input logic [31:0] d);
    int w;
    SW = sw;
    Input_Data = d;
    @(posedge Clk);
    model(sw, d);
    #1;
    w = (m_cnt / 4) % 8;
    chk("out", Output_Data, m_out);
    chk("which", {29'd0, which}, w);
    chk("led", {24'd0, led}, {24'd0, hex7(m_out[w*4 +: 4])});
    chk("shine", {31'd0, shine}, (m_cnt / 32) % 2);
  endtask

  localparam logic [5:0] RST = 6'h01, LDA = 6'h02, LDD = 6'h04;
  localparam logic [5:0] WR  = 6'h08, CAP = 6'h10, SEL = 6'h20;

  initial begin
    logic [5:0] sw;
    step(RST, 32'h0);
    chk("rst_out", Output_Data, 32'h0);
    chk("rst_led", {24'd0, led}, 32'hC0);

    for (int i = 0; i < 32; i++) begin
      step(LDA, i << 8);
      step(CAP, 32'h0);
      chk("rst_reg", Output_Data, 32'h0);
    end

    step(LDA, 32'h0);
    step(LDD, 32'hFFFF_FFFF);
    step(WR, 32'h0);
    step(CAP, 32'h0);
    chk("r0_ignored", Output_Data, 32'h0);

    step(LDA, 32'h004A_0F01);
    step(LDD, 32'h0000_00F1);
    step(WR, 32'h0);
    step(LDA, 32'h0000_0100);
    step(CAP, 32'h0);
    chk("read_a", Output_Data, 32'h0000_00F1);
    step(LDA, 32'h0001_0000);
    step(CAP | SEL, 32'h0);
    chk("read_b", Output_Data, 32'h0000_00F1);

    step(LDA, 32'h0000_0101);
    step(LDD, 32'h1234_5678);
    step(WR | CAP, 32'h0);
    chk("no_bypass", Output_Data, 32'h0000_00F1);
    step(CAP, 32'h0);
    chk("after_wr", Output_Data, 32'h1234_5678);
    step(LDD, 32'h0000_00F1);
    step(WR | CAP, 32'h0);
    step(CAP, 32'h0);
    chk("restore", Output_Data, 32'h0000_00F1);

    step(RST | CAP, 32'h0);
    step(LDA, 32'h0000_0101);
    step(LDD, 32'h0000_00F1);
    step(WR, 32'h0);
    step(CAP, 32'h0);
    step(RST, 32'h0);
    chk("rst_clears", Output_Data, 32'h0);
    step(LDA, 32'h0000_0101);
    step(LDD, 32'h0000_00F1);
    step(WR, 32'h0);
    step(CAP, 32'h0);
    for (int i = 0; i < 64; i++) step(6'h00, 32'h0);

    for (int i = 0; i < 600; i++) begin
      sw = 6'($urandom_range(0, 63));
      if (sw[0] && $urandom_range(0, 15) != 0) sw[0] = 1'b0;
      step(sw, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
